// File: rtl/md_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The pipeline drives start/op/A/B/flush; the unit returns busy and HI/LO.
interface md_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, A, B, flush, input busy, HI, LO);
  modport slave  (input start, op, A, B, flush, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO. It uses a combinational datapath on
// latched operands, and a down-counter fixes the commit edge per operation class.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);
  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic               a_neg, b_neg, sgn_div;
  logic [WIDTH-1:0]   dvd, dvs, q_mag, r_mag, quot, rem;

  // One divider serves both DIV and DIVU by running on magnitudes. The
  // most-negative / -1 case falls out naturally: |A| = 2^(W-1), q = A, r = 0.
  always_comb begin
    prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    sgn_div = (op_q == 4'd3);
    a_neg   = sgn_div & a_q[WIDTH-1];
    b_neg   = sgn_div & b_q[WIDTH-1];
    dvd     = a_neg ? -a_q : a_q;
    dvs     = b_neg ? -b_q : b_q;
    q_mag   = dvd / dvs;
    r_mag   = dvd % dvs;
    quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
    case (op_q)
      4'd1:       res = prod_s;
      4'd2:       res = prod_u;
      4'd3, 4'd4: res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
      default:    res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            4'd1, 4'd2, 4'd3, 4'd4: begin
              a_d     = bus.A;
              b_d     = bus.B;
              op_d    = bus.op;
              cnt_d   = (bus.op <= 4'd2) ? CW'(MULT_LAT) : CW'(DIV_LAT);
              state_d = RUN;
            end
            4'd5:    hi_d = bus.A;
            4'd6:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            hi_d    = res[2*WIDTH-1:WIDTH];
            lo_d    = res[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed spec cases plus randomized ops
// against a plain-arithmetic HI/LO model.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) bi0 ();
  md_unit_if #(.WIDTH(32)) bi1 ();

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u0 (.clk(clk), .reset(reset), .bus(bi0));
  md_unit #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(32)) u1 (.clk(clk), .reset(reset), .bus(bi1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    case (o)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); hi = p[63:32]; lo = p[31:0]; end
      4'd2: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      4'd3: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
        else begin sa = a; sb = b; lo = sa / sb; hi = sa % sb; end
      end
      4'd4: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      4'd5: hi = a;
      4'd6: lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bi0.start = 1'b1; bi0.op = o; bi0.A = a; bi0.B = b;
    @(negedge clk);
    bi0.start = 1'b0; bi0.op = 4'd0;
  endtask

  task automatic wait_idle(output int n, input bit scramble);
    n = 0;
    while (bi0.busy === 1'b1 && n < 200) begin
      if (scramble) begin bi0.A = $urandom; bi0.B = $urandom; end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic directed(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat);
    int n;
    issue(o, a, b);
    wait_idle(n, 1'b0);
    chk({tag, " busy_cycles"}, 32'(n), 32'(elat));
    chk({tag, " HI"}, bi0.HI, ehi);
    chk({tag, " LO"}, bi0.LO, elo);
    mhi = ehi; mlo = elo;
  endtask

  initial begin
    int          n;
    logic [3:0]  o;
    logic [31:0] a, b;
    int          r;

    bi0.start = 0; bi0.op = 0; bi0.A = 0; bi0.B = 0; bi0.flush = 0;
    bi1.start = 0; bi1.op = 0; bi1.A = 0; bi1.B = 0; bi1.flush = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset busy", 32'(bi0.busy), 32'd0);
    chk("reset HI", bi0.HI, 32'd0);
    chk("reset LO", bi0.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    directed("MULT -3*5",  4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    directed("MULTU",      4'd2, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 5);
    directed("DIVU 7/2",   4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    directed("DIV -7/2",   4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    directed("DIV ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    directed("DIV by 0",   4'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 10);

    // MTHI then MULT with an MTLO issued while busy (must be dropped)
    issue(4'd5, 32'hAAAA_5555, 32'd0);
    chk("MTHI HI", bi0.HI, 32'hAAAA_5555);
    chk("MTHI busy", 32'(bi0.busy), 32'd0);
    issue(4'd1, 32'd2, 32'd3);
    issue(4'd6, 32'h77, 32'd0);
    wait_idle(n, 1'b0);
    chk("MTLO-while-busy HI", bi0.HI, 32'd0);
    chk("MTLO-while-busy LO", bi0.LO, 32'd6);
    mhi = 0; mlo = 6;

    // Flush on the third busy cycle, with a start held in the same cycle
    issue(4'd6, 32'h11, 32'd0);
    chk("MTLO LO", bi0.LO, 32'h11);
    mlo = 32'h11;
    issue(4'd1, 32'd9, 32'd9);
    @(negedge clk);
    @(negedge clk);
    bi0.flush = 1'b1; bi0.start = 1'b1; bi0.op = 4'd6; bi0.A = 32'h99;
    @(negedge clk);
    bi0.flush = 1'b0; bi0.start = 1'b0; bi0.op = 4'd0;
    chk("flush busy", 32'(bi0.busy), 32'd0);
    chk("flush LO", bi0.LO, 32'h11);
    chk("flush HI", bi0.HI, mhi);
    repeat (8) @(negedge clk);
    chk("post-flush LO", bi0.LO, 32'h11);

    // Randomized ops; operands scrambled on the bus while running
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      r = $urandom_range(0, 7);
      if (o == 4'd3 || o == 4'd4) begin
        if (r == 0) b = 0;
        else if (r == 1 && o == 4'd3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        else if (r < 4) b = $urandom_range(1, 20);
      end
      model(o, a, b, mhi, mlo);
      issue(o, a, b);
      wait_idle(n, 1'b1);
      if (o <= 4'd4) chk("rand busy_cycles", 32'(n), (o <= 4'd2) ? 32'd5 : 32'd10);
      else chk("rand MT busy", 32'(n), 32'd0);
      chk("rand HI", bi0.HI, mhi);
      chk("rand LO", bi0.LO, mlo);
    end

    // Alternate latencies on the second instance
    bi1.start = 1'b1; bi1.op = 4'd1; bi1.A = 32'd3; bi1.B = 32'd4;
    @(negedge clk);
    bi1.start = 1'b0; bi1.op = 4'd0;
    n = 0;
    while (bi1.busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("lat1 MULT busy_cycles", 32'(n), 32'd1);
    chk("lat1 MULT LO", bi1.LO, 32'd12);
    bi1.start = 1'b1; bi1.op = 4'd4; bi1.A = 32'd100; bi1.B = 32'd7;
    @(negedge clk);
    bi1.start = 1'b0; bi1.op = 4'd0;
    n = 0;
    while (bi1.busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("lat32 DIVU busy_cycles", 32'(n), 32'd32);
    chk("lat32 DIVU LO", bi1.LO, 32'd14);
    chk("lat32 DIVU HI", bi1.HI, 32'd2);

    // Async reset mid-DIV: clears immediately, no later commit
    issue(4'd4, 32'd100, 32'd3);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async rst busy", 32'(bi0.busy), 32'd0);
    chk("async rst HI", bi0.HI, 32'd0);
    chk("async rst LO", bi0.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post-rst busy", 32'(bi0.busy), 32'd0);
    chk("post-rst HI", bi0.HI, 32'd0);
    chk("post-rst LO", bi0.LO, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the execute stage of the pipelined MIPS core. It runs alongside the single-cycle ALU and owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run over a fixed, configurable number of cycles; MTHI/MTLO commit in one cycle. It provides a busy flag for hazard stalls and a flush input that cancels an operation on an exception.

## Interface
- WIDTH, 32, operand, HI and LO width in bits (≥2)
- MULT_LAT, 5, busy cycles for MULT/MULTU (≥1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (≥1)
- clk  in  1  pipeline clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  issue strobe; sampled at the rising edge
- op  in  4  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7–15 no-op
- A  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source)
- B  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  synchronous cancel of an in-flight operation
- busy  out  1  an operation is in flight; HI/LO not yet final
- HI  out  WIDTH  HI register (MFHI source)
- LO  out  WIDTH  LO register (MFLO source)

## Operation
- States: IDLE, RUN. Reset (reset=0) → IDLE, busy=0, HI=0, LO=0, cycle counter=0, operand latches=0.
- IDLE, edge with start=1 and flush=0:
  - op 1–4: latch A, B and op. Load counter with MULT_LAT or DIV_LAT. Go to RUN.
  - op 5: HI←A. Op 6: LO←A. Stay in IDLE.
  - Any other op: no effect.
- RUN: counter decrements each edge. On the edge where the counter reaches 0, HI/LO take the result and the state returns to IDLE.
- Results are computed only from the latched operands. A/B changes during RUN have no effect. The datapath is free (iterative or combinational); the commit cycle is fixed by the parameter.
- MULT: signed 2·WIDTH-bit product; HI = upper half, LO = lower half. MULTU: same, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (B=0, DIV or DIVU): LO = all ones, HI = A.
- Signed overflow (DIV, A = most-negative value, B = −1): LO = A, HI = 0.
- start while busy=1 is ignored entirely, including MTHI/MTLO. Control must stall any MD instruction or MFHI/MFLO while (busy | start·(op∈1..4)).
- flush=1 at an edge:
  - RUN → IDLE; HI/LO keep their pre-operation values.
  - A start in the same cycle is ignored.
  - flush in IDLE has no effect.
- Asynchronous reset during RUN aborts the operation. All outputs return to their reset values immediately.

## Timing
- Issue at edge T (start=1, op 1–4, IDLE): busy=1 from T to T+L, where L = MULT_LAT or DIV_LAT. busy is high for exactly L cycles.
- At edge T+L, HI/LO update and busy falls. New HI/LO are visible in the cycle after T+L. A new start is accepted at edge T+L+1.
- Back-to-back: a start sampled at edge T+L is ignored (busy=1 at that edge).
- MTHI/MTLO at edge T: value is visible on HI/LO after T. busy stays 0.
- HI, LO and busy are registered outputs; there is no combinational path from any input.

## Test plan
- Reset: reset=0 mid-stream → HI=0, LO=0, busy=0 immediately, without waiting for an edge.
- MULT A=0xFFFFFFFD (−3), B=5 → busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- Division, each busy for 10 cycles:
  - DIVU 7/2 → LO=3, HI=1.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIV A=0x1234, B=0 → LO=0xFFFFFFFF, HI=0x00001234.
- MTHI A=0xAAAA5555 → HI=0xAAAA5555 next cycle, busy stays 0. Then MULT 2×3 followed by MTLO 0x77 while busy → MTLO ignored; final HI=0, LO=6.
- Flush: MTLO 0x11; MULT 9×9; flush=1 on the 3rd busy cycle → busy=0 next cycle, LO stays 0x11. A start held with flush in that cycle → ignored.
- Overrides:
  - Change A/B during RUN → result still uses the latched operands.
  - Re-run with MULT_LAT=1, DIV_LAT=32 → busy widths are 1 and 32 cycles.
  - Async reset asserted mid-DIV → the operation aborts and no HI/LO commit occurs.
